// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader: FSM state encoding and default geometry.
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/ram_stream_reader.sv
// Walks a window of RAM addresses and streams each word out on a valid/ready interface.
//
//  state | meaning
//  IDLE  | waiting for start; done low
//  FETCH | RAM presents word at ram_addr; captured into out_data at the edge
//  SEND  | out_data valid, held stable until the consumer accepts
//  DONE  | one-cycle done pulse, busy drops
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_L     = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t          state;
    logic [ADDR_W:0] remaining;
    logic [ADDR_W:0] eff_len;

    // A zero length means a full sweep; anything past the RAM size is clamped to it.
    always_comb begin
        eff_len = len;
        if (len == '0 || len > DEPTH_L) begin
            eff_len = DEPTH_L;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ram_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ram_addr  <= start_addr;
                        remaining <= eff_len;
                        busy      <= 1'b1;
                        state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    out_data  <= ram_rd_data;
                    out_valid <= 1'b1;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (remaining == ONE_L) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            ram_addr  <= (ram_addr == LAST_ADDR) ? '0 : ram_addr + 1'b1;
                            remaining <= remaining - 1'b1;
                            state     <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
